// File: rtl/kernel_fetch_sequencer_if.sv
// Kernel stream bundle between the fetch sequencer and the MAC array.
// Latency: none, wires only.
// Backpressure: the consumer drives m_ker_ready; the producer holds the payload until the handshake.
// Ports: m_ker_valid/m_ker_data/m_ker_last (producer to consumer), m_ker_ready (consumer to producer).
interface kernel_fetch_sequencer_if #(
   parameter int DATA_W = 144
) ();
   logic              m_ker_valid;
   logic              m_ker_ready;
   logic [DATA_W-1:0] m_ker_data;
   logic              m_ker_last;

   modport master (
      output m_ker_valid,
      output m_ker_data,
      output m_ker_last,
      input  m_ker_ready
   );

   modport slave (
      input  m_ker_valid,
      input  m_ker_data,
      input  m_ker_last,
      output m_ker_ready
   );
endinterface

// File: rtl/kernel_fetch_sequencer.sv
// Fetches one 3x3 kernel per channel from the kernel BRAM and hands it to the MAC array.
// Latency: start to first valid is RD_LAT+2 cycles when the BRAM unit is already idle.
// Backpressure: the kernel is held in the output slice until m_ker_ready; the BRAM address only advances after acceptance.
// Ports: clk/Reset (async, active low); start + CHANNEL_SIZE launch a sequence;
//        kernel_bram_idle/ker_doutb/update_BRAM_doutb talk to the BRAM control unit;
//        kif carries the kernel stream; busy/done report sequence status.
module kernel_fetch_sequencer #(
   parameter int WEIGHT_W = 16,
   parameter int TAPS     = 9,
   parameter int RD_LAT   = 2
) (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       start,
   input  logic [8:0]                 CHANNEL_SIZE,
   input  logic                       kernel_bram_idle,
   input  logic [TAPS*WEIGHT_W-1:0]   ker_doutb,
   output logic                       update_BRAM_doutb,
   output logic                       busy,
   output logic                       done,
   kernel_fetch_sequencer_if.master   kif
);
   localparam int DATA_W = TAPS * WEIGHT_W;
   localparam int SET_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_CU, SETTLE, HOLD, ADVANCE, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [8:0]        size_q, size_d;
   logic [8:0]        chan_cnt_q, chan_cnt_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              is_last_chan;

   // Only evaluated after a nonzero size has been latched, so size_q-1 never underflows in use.
   assign is_last_chan = (chan_cnt_q == size_q - 9'd1);

   always_comb begin
      state_d           = state_q;
      size_d            = size_q;
      chan_cnt_d        = chan_cnt_q;
      settle_d          = settle_q;
      data_d            = data_q;
      valid_d           = valid_q;
      last_d            = last_q;
      update_BRAM_doutb = 1'b0;
      done              = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               size_d     = CHANNEL_SIZE;
               chan_cnt_d = 9'd0;
               state_d    = (CHANNEL_SIZE != 9'd0) ? WAIT_CU : DONE;
            end
         end
         WAIT_CU: begin
            if (kernel_bram_idle) begin
               settle_d = '0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            // doutb is trusted only on the final settle cycle, after the BRAM read latency.
            if (settle_q == SET_LAST) begin
               data_d   = ker_doutb;
               valid_d  = 1'b1;
               last_d   = is_last_chan;
               settle_d = '0;
               state_d  = HOLD;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         HOLD: begin
            if (valid_q && kif.m_ker_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = ADVANCE;
            end
         end
         ADVANCE: begin
            // Pulse even after the last kernel so the control unit's read pointer stays in step.
            update_BRAM_doutb = 1'b1;
            if (is_last_chan) begin
               state_d = DONE;
            end else begin
               chan_cnt_d = chan_cnt_q + 9'd1;
               state_d    = WAIT_CU;
            end
         end
         DONE: begin
            done       = 1'b1;
            chan_cnt_d = 9'd0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         size_q     <= 9'd0;
         chan_cnt_q <= 9'd0;
         settle_q   <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         chan_cnt_q <= chan_cnt_d;
         settle_q   <= settle_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign kif.m_ker_valid = valid_q;
   assign kif.m_ker_data  = data_q;
   assign kif.m_ker_last  = last_q;
endmodule

// File: tb/tb_kernel_fetch_sequencer.sv
// Bench for kernel_fetch_sequencer: BRAM/control-unit model plus an event-timestamp reference model.
// Latency: expectations are derived per cycle from accepted starts, handshakes and idle edges.
// Backpressure: ready is driven always-high, randomly, or held low by the directed sequences.
`timescale 1ns/1ps
module tb_kernel_fetch_sequencer;
   localparam int WEIGHT_W = 16;
   localparam int TAPS     = 9;
   localparam int RD_LAT   = 2;
   localparam int DATA_W   = TAPS * WEIGHT_W;

   logic              clk = 1'b0;
   logic              Reset;
   logic              start;
   logic [8:0]        channel_size;
   logic              kernel_bram_idle;
   logic [DATA_W-1:0] ker_doutb;
   logic              update_BRAM_doutb;
   logic              busy;
   logic              done;

   kernel_fetch_sequencer_if #(.DATA_W(DATA_W)) kif ();

   kernel_fetch_sequencer #(
      .WEIGHT_W (WEIGHT_W),
      .TAPS     (TAPS),
      .RD_LAT   (RD_LAT)
   ) dut (
      .clk               (clk),
      .Reset             (Reset),
      .start             (start),
      .CHANNEL_SIZE      (channel_size),
      .kernel_bram_idle  (kernel_bram_idle),
      .ker_doutb         (ker_doutb),
      .update_BRAM_doutb (update_BRAM_doutb),
      .busy              (busy),
      .done              (done),
      .kif               (kif.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_dat(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Each word of a kernel carries the BRAM address and its tap index.
   function automatic logic [DATA_W-1:0] mk_tag(input int a);
      logic [DATA_W-1:0] t;
      logic [7:0]        ab;
      ab = a[7:0];
      for (int i = 0; i < TAPS; i++) t[i*WEIGHT_W +: WEIGHT_W] = {ab, 8'(i)};
      return t;
   endfunction

   function automatic logic [DATA_W-1:0] mk_noise();
      logic [DATA_W-1:0] t;
      for (int i = 0; i < TAPS; i++) t[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'($urandom);
      return t;
   endfunction

   // Control-unit knobs (driver owned)
   int cu_dly  = 3;
   bit cu_hold = 1'b0;
   // Control-unit / BRAM state (monitor owned)
   int addr = 0;
   int cu_wait = 0;
   // Reference model state
   bit m_active;
   int m_size, m_base, m_k;
   bit m_waiting;
   int m_wait_from, m_vld_at, m_upd_at, m_done_at;
   bit exp_vld, hs, start_ok;
   // Sequence statistics
   int n_hs, n_upd, n_done, n_last, first_vld;
   int t0;

   task automatic model_clear();
      m_active = 1'b0; m_size = 0; m_base = 0; m_k = 0;
      m_waiting = 1'b0; m_wait_from = 0;
      m_vld_at = -1; m_upd_at = -1; m_done_at = -1;
   endtask

   // Monitor, reference model and control-unit model, all evaluated mid-cycle.
   initial begin
      kernel_bram_idle = 1'b1;
      ker_doutb        = '0;
      model_clear();
      forever begin
         @(negedge clk);
         if (!Reset) begin
            check_int("rst_valid",  int'(kif.m_ker_valid), 0);
            check_dat("rst_data",   kif.m_ker_data, '0);
            check_int("rst_last",   int'(kif.m_ker_last), 0);
            check_int("rst_update", int'(update_BRAM_doutb), 0);
            check_int("rst_done",   int'(done), 0);
            check_int("rst_busy",   int'(busy), 0);
            model_clear();
            addr = 0;
            cu_wait = 0;
            kernel_bram_idle = !cu_hold;
            ker_doutb = mk_tag(addr);
         end else begin
            exp_vld = (m_vld_at >= 0) && (cyc >= m_vld_at);
            check_int("valid", int'(kif.m_ker_valid), int'(exp_vld));
            if (exp_vld) begin
               check_dat("data", kif.m_ker_data, mk_tag(m_base + m_k));
               check_int("last", int'(kif.m_ker_last), int'(m_k == m_size - 1));
            end
            check_int("update", int'(update_BRAM_doutb), int'(cyc == m_upd_at));
            check_int("done",   int'(done), int'(cyc == m_done_at));
            check_int("busy",   int'(busy), int'(m_active));

            if (kif.m_ker_valid && first_vld < 0) first_vld = cyc;
            if (kif.m_ker_valid && kif.m_ker_ready) begin
               n_hs++;
               if (kif.m_ker_last) n_last++;
            end
            if (update_BRAM_doutb) n_upd++;
            if (done) n_done++;

            // Control unit: busy for cu_dly cycles after each update, address bumps on update.
            if (update_BRAM_doutb) begin
               addr++;
               cu_wait = cu_dly;
            end else if (cu_wait > 0) begin
               cu_wait--;
            end
            kernel_bram_idle = (cu_wait == 0) && !cu_hold;
            // doutb is only meaningful while idle and not holding a kernel; otherwise it is noise.
            ker_doutb = (kernel_bram_idle && !kif.m_ker_valid) ? mk_tag(addr) : mk_noise();

            // Reference model: project next events from this cycle's inputs.
            start_ok = !m_active && start;
            hs       = exp_vld && kif.m_ker_ready;
            if (m_waiting && cyc >= m_wait_from && kernel_bram_idle) begin
               m_vld_at  = cyc + 1 + RD_LAT;
               m_waiting = 1'b0;
            end
            if (hs) begin
               m_vld_at = -1;
               m_upd_at = cyc + 1;
               m_k++;
               if (m_k == m_size) m_done_at = cyc + 2;
               else begin
                  m_waiting   = 1'b1;
                  m_wait_from = cyc + 2;
               end
            end
            if (m_active && cyc == m_done_at) m_active = 1'b0;
            if (start_ok) begin
               m_active = 1'b1;
               m_size   = int'(channel_size);
               m_base   = addr;
               m_k      = 0;
               if (channel_size == 9'd0) m_done_at = cyc + 1;
               else begin
                  m_waiting   = 1'b1;
                  m_wait_from = cyc + 1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      n_hs = 0; n_upd = 0; n_done = 0; n_last = 0; first_vld = -1;
   endtask

   task automatic pulse_start(input int size);
      start = 1'b1;
      channel_size = 9'(size);
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_done(input int rmode, input int budget);
      int n;
      n = 0;
      while (n_done == 0 && n < budget) begin
         kif.m_ker_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check_int("done_within_budget", n_done, 1);
   endtask

   typedef struct {
      int size;
      int rmode;
      int cu_dly;
      int exp_kern;
      int exp_upd;
      int exp_last;
      int exp_lat;
   } vec_t;

   vec_t vec[6];
   int lat, sz, n, r;
   logic [DATA_W-1:0] snap_d;
   logic              snap_l;

   initial begin
      vec[0] = '{3, 0, 3, 3, 3, 1, 4};
      vec[1] = '{1, 0, 3, 1, 1, 1, 4};
      vec[2] = '{0, 0, 3, 0, 0, 0, -1};
      vec[3] = '{5, 1, 5, 5, 5, 1, 4};
      vec[4] = '{2, 1, 3, 2, 2, 1, 4};
      vec[5] = '{4, 0, 7, 4, 4, 1, 4};

      Reset = 1'b0; start = 1'b0; channel_size = 9'd0; kif.m_ker_ready = 1'b0;
      clr_stats();
      repeat (3) tick();
      check_int("reset_busy",  int'(busy), 0);
      check_int("reset_valid", int'(kif.m_ker_valid), 0);
      Reset = 1'b1;
      tick();

      // Table-driven sequences
      for (int i = 0; i < 6; i++) begin
         cu_dly = vec[i].cu_dly;
         repeat (10) tick();
         clr_stats();
         kif.m_ker_ready = 1'b1;
         pulse_start(vec[i].size);
         run_to_done(vec[i].rmode, 400);
         lat = (first_vld < 0) ? -1 : first_vld - t0;
         check_int("tbl_kernels", n_hs, vec[i].exp_kern);
         check_int("tbl_updates", n_upd, vec[i].exp_upd);
         check_int("tbl_lasts",   n_last, vec[i].exp_last);
         check_int("tbl_first_latency", lat, vec[i].exp_lat);
      end

      // Randomized sequences
      for (int i = 0; i < 12; i++) begin
         cu_dly = $urandom_range(3, 6);
         sz = $urandom_range(0, 6);
         repeat (10) tick();
         clr_stats();
         kif.m_ker_ready = 1'($urandom_range(0, 1));
         pulse_start(sz);
         run_to_done(1, 600);
         check_int("rnd_kernels", n_hs, sz);
         check_int("rnd_updates", n_upd, sz);
         check_int("rnd_lasts",   n_last, (sz > 0) ? 1 : 0);
      end
      cu_dly = 3;

      // Backpressure: ready low for 7 cycles while a kernel is held
      repeat (10) tick();
      clr_stats();
      kif.m_ker_ready = 1'b0;
      pulse_start(2);
      n = 0;
      while (!kif.m_ker_valid && n < 50) begin tick(); n++; end
      check_int("bp_valid_seen", int'(kif.m_ker_valid), 1);
      snap_d = kif.m_ker_data;
      snap_l = kif.m_ker_last;
      repeat (7) begin
         tick();
         check_dat("bp_data_stable", kif.m_ker_data, snap_d);
         check_int("bp_last_stable", int'(kif.m_ker_last), int'(snap_l));
         check_int("bp_no_update", n_upd, 0);
      end
      kif.m_ker_ready = 1'b1;
      tick();
      kif.m_ker_ready = 1'b0;
      tick();
      tick();
      check_int("bp_one_update", n_upd, 1);
      run_to_done(0, 200);
      check_int("bp_kernels", n_hs, 2);
      check_int("bp_updates", n_upd, 2);

      // Control unit held busy for 20 cycles after start
      repeat (10) tick();
      clr_stats();
      cu_hold = 1'b1;
      kif.m_ker_ready = 1'b1;
      pulse_start(1);
      repeat (20) tick();
      check_int("hold_no_valid", first_vld, -1);
      check_int("hold_busy", int'(busy), 1);
      cu_hold = 1'b0;
      r = cyc;
      n = 0;
      while (first_vld < 0 && n < 20) begin tick(); n++; end
      check_int("release_latency", first_vld - r, RD_LAT + 1);
      run_to_done(0, 100);
      check_int("hold_kernels", n_hs, 1);

      // start while busy must not relaunch or relatch the size
      repeat (10) tick();
      clr_stats();
      kif.m_ker_ready = 1'b1;
      pulse_start(3);
      repeat (3) tick();
      start = 1'b1;
      channel_size = 9'd7;
      tick();
      start = 1'b0;
      run_to_done(0, 200);
      check_int("busy_start_kernels", n_hs, 3);
      check_int("busy_start_lasts", n_last, 1);

      // Reset while holding channel 2 of a 4-channel set, then a clean 2-channel run
      repeat (10) tick();
      clr_stats();
      kif.m_ker_ready = 1'b1;
      pulse_start(4);
      n = 0;
      while (n_hs < 2 && n < 100) begin tick(); n++; end
      kif.m_ker_ready = 1'b0;
      n = 0;
      while (!kif.m_ker_valid && n < 50) begin tick(); n++; end
      check_int("rst_setup_hs", n_hs, 2);
      check_int("rst_setup_valid", int'(kif.m_ker_valid), 1);
      tick();
      #2;
      Reset = 1'b0;
      #1;
      check_int("async_rst_valid",  int'(kif.m_ker_valid), 0);
      check_dat("async_rst_data",   kif.m_ker_data, '0);
      check_int("async_rst_last",   int'(kif.m_ker_last), 0);
      check_int("async_rst_update", int'(update_BRAM_doutb), 0);
      check_int("async_rst_busy",   int'(busy), 0);
      tick();
      tick();
      Reset = 1'b1;
      tick();
      clr_stats();
      kif.m_ker_ready = 1'b1;
      pulse_start(2);
      run_to_done(0, 200);
      check_int("post_rst_kernels", n_hs, 2);
      check_int("post_rst_lasts",   n_last, 1);
      check_int("post_rst_updates", n_upd, 2);

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
